// File: rtl/imem_loader.sv
`timescale 1ns/1ps
// imem_loader
// Runtime instruction-memory loader. Takes a framed byte stream from a
// valid/ready byte source, writes ILEN-bit words into the instruction memory
// write port and keeps the CPU held until a complete frame with a good
// checksum has been written.
//
// Frame: LEN_LO, LEN_HI (word count N, little-endian), N words of ILEN/8
// bytes each (little-endian), then one checksum byte equal to the 8-bit
// wrap-around sum of every byte before it.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-low reset
//   rx_valid_i   byte available from the source
//   rx_ready_o   loader accepts a byte this cycle (function of state only)
//   rx_data_i    byte data
//   reload_i     single-cycle pulse, restarts loading from RUN or ERR
//   imem_we_o    imem write strobe, one cycle per word
//   imem_addr_o  imem word address
//   imem_wdata_o imem write data
//   cpu_run_o    releases the CPU
//   busy_o       frame reception in progress
//   err_o        00 none, 01 checksum, 10 length, 11 timeout
module imem_loader #(
  parameter int ILEN           = 32,
  parameter int IMEM_DEPTH     = 1024,
  parameter int ADDR_W         = $clog2(IMEM_DEPTH),
  parameter int BASE_ADDR      = 0,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  input  logic [7:0]        rx_data_i,
  input  logic              reload_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [ILEN-1:0]   imem_wdata_o,
  output logic              cpu_run_o,
  output logic              busy_o,
  output logic [1:0]        err_o
);

  localparam int BYTES  = ILEN / 8;
  localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_LENGTH  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [15:0]         wordCnt_q, wordCnt_d;
  logic [BCNT_W-1:0]   byteCnt_q, byteCnt_d;
  logic [ILEN-1:0]     shift_q, shift_d;
  logic [7:0]          sum_q, sum_d;
  logic [TO_W-1:0]     toCnt_q, toCnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ILEN-1:0]     wdata_q, wdata_d;
  logic                run_q, run_d;
  logic [1:0]          err_q, err_d;

  logic                accept;
  logic                inFrame;
  logic                lastByte;
  logic                timedOut;
  logic [15:0]         lenFull;
  logic [ILEN-1:0]     wordNext;

  // Ready and busy are pure decodes of the state register, so the byte
  // source never sees a combinational path back from rx_valid_i.
  assign rx_ready_o = (state_q == S_LEN_LO) || inFrame;
  assign busy_o     = inFrame;
  assign inFrame    = (state_q == S_LEN_HI) || (state_q == S_DATA) || (state_q == S_CSUM);

  assign accept   = rx_valid_i && rx_ready_o;
  assign lastByte = (byteCnt_q == LAST_BYTE);
  assign lenFull  = {rx_data_i, len_q[7:0]};
  // New bytes enter at the top and drift down, so the first byte of a word
  // ends up in the least significant lane (little-endian).
  assign wordNext = ILEN'({rx_data_i, shift_q} >> 8);
  // An accepted byte on the terminal count wins over the timeout.
  assign timedOut = (TIMEOUT_CYCLES != 0) && inFrame && !accept && (toCnt_q == TO_LAST);

  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign cpu_run_o    = run_q;
  assign err_o        = err_q;

  // Next-state logic for the frame parser. The write strobe is a one-cycle
  // pulse and the address advances on the cycle after each write, which
  // lets words arrive back to back without a stall.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wordCnt_d = wordCnt_q;
    byteCnt_d = byteCnt_q;
    shift_d   = shift_q;
    sum_d     = sum_q;
    toCnt_d   = toCnt_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    run_d     = run_q;
    err_d     = err_q;

    if (!inFrame || accept) begin
      toCnt_d = '0;
    end else if (TIMEOUT_CYCLES != 0) begin
      toCnt_d = toCnt_q + TO_W'(1);
    end

    if (accept && (state_q != S_CSUM)) begin
      sum_d = sum_q + rx_data_i;
    end

    if (we_q) begin
      addr_d = addr_q + ADDR_W'(1);
    end

    case (state_q)
      S_LEN_LO: begin
        if (accept) begin
          len_d   = {8'h00, rx_data_i};
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d     = lenFull;
          wordCnt_d = '0;
          byteCnt_d = '0;
          if (32'(lenFull) > 32'(IMEM_DEPTH)) begin
            state_d = S_ERR;
            err_d   = ERR_LENGTH;
          end else if (lenFull == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end else if (timedOut) begin
          state_d = S_ERR;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_DATA: begin
        if (accept) begin
          shift_d = wordNext;
          if (lastByte) begin
            byteCnt_d = '0;
            we_d      = 1'b1;
            wdata_d   = wordNext;
            wordCnt_d = wordCnt_q + 16'd1;
            if (wordCnt_q == len_q - 16'd1) begin
              state_d = S_CSUM;
            end
          end else begin
            byteCnt_d = byteCnt_q + BCNT_W'(1);
          end
        end else if (timedOut) begin
          state_d = S_ERR;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (rx_data_i == sum_q) begin
            state_d = S_RUN;
            run_d   = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = ERR_CSUM;
          end
        end else if (timedOut) begin
          state_d = S_ERR;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_RUN, S_ERR: begin
        if (reload_i) begin
          state_d   = S_LEN_LO;
          run_d     = 1'b0;
          err_d     = ERR_NONE;
          addr_d    = BASE;
          sum_d     = '0;
          toCnt_d   = '0;
          wordCnt_d = '0;
          byteCnt_d = '0;
        end
      end
      default: begin
        state_d = S_LEN_LO;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight write.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_LEN_LO;
      len_q     <= '0;
      wordCnt_q <= '0;
      byteCnt_q <= '0;
      shift_q   <= '0;
      sum_q     <= '0;
      toCnt_q   <= '0;
      we_q      <= 1'b0;
      addr_q    <= BASE;
      wdata_q   <= '0;
      run_q     <= 1'b0;
      err_q     <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      wordCnt_q <= wordCnt_d;
      byteCnt_q <= byteCnt_d;
      shift_q   <= shift_d;
      sum_q     <= sum_d;
      toCnt_q   <= toCnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      run_q     <= run_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
// tb_imem_loader
// Directed and randomized frames driven into imem_loader. Expected writes
// are simply (k, word k) for each frame word, and the checksum byte is the
// byte-wise sum of the frame, both computed here from the frame contents.
module tb_imem_loader;

  localparam int ILEN  = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int TO    = 16;
  localparam int NB    = ILEN / 8;

  logic            clk = 1'b0;
  logic            rstN = 1'b0;
  logic            rxValid = 1'b0;
  logic            reload = 1'b0;
  logic [7:0]      rxData = 8'h00;
  logic            rxReady;
  logic            imemWe;
  logic [AW-1:0]   imemAddr;
  logic [ILEN-1:0] imemWdata;
  logic            cpuRun;
  logic            busy;
  logic [1:0]      err;

  imem_loader #(
    .ILEN(ILEN), .IMEM_DEPTH(DEPTH), .ADDR_W(AW), .BASE_ADDR(0), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rstN), .rx_valid_i(rxValid), .rx_ready_o(rxReady),
    .rx_data_i(rxData), .reload_i(reload), .imem_we_o(imemWe),
    .imem_addr_o(imemAddr), .imem_wdata_o(imemWdata), .cpu_run_o(cpuRun),
    .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  int              vectors = 0;
  int              miscompares = 0;
  int              stallPct = 0;
  bit              reloadNoise = 1'b0;
  logic [AW-1:0]   gotAddr[$];
  logic [ILEN-1:0] gotData[$];
  logic [ILEN-1:0] words[$];

  // Capture every imem write mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    if (imemWe === 1'b1) begin
      gotAddr.push_back(imemAddr);
      gotData.push_back(imemWdata);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time budget exhausted, observed no finish, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one byte, optionally after a few idle (valid low) cycles. Returns
  // at 1 ns after the edge that accepted it.
  task automatic applyStimulus(input logic [7:0] b);
    int gap;
    int w;
    gap = 0;
    if (stallPct > 0 && int'($urandom_range(99)) < stallPct) gap = int'($urandom_range(3, 1));
    rxValid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      reload = reloadNoise && ($urandom_range(1) == 1);
      @(posedge clk); #1;
      reload = 1'b0;
    end
    rxData  = b;
    rxValid = 1'b1;
    w = 0;
    while (rxReady !== 1'b1 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (rxReady !== 1'b1) begin
      checkOutput("ready_wait", 32'(rxReady), 32'd1);
      rxValid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    rxValid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, 32'(rxReady), 32'd1);
    checkOutput({tag, "_we"},    32'(imemWe), 32'd0);
    checkOutput({tag, "_addr"},  32'(imemAddr), 32'd0);
    checkOutput({tag, "_wdata"}, 32'(imemWdata), 32'd0);
    checkOutput({tag, "_run"},   32'(cpuRun), 32'd0);
    checkOutput({tag, "_busy"},  32'(busy), 32'd0);
    checkOutput({tag, "_err"},   32'(err), 32'd0);
  endtask

  task automatic checkWrites(input string tag);
    checkOutput({tag, "_wcount"}, 32'(gotAddr.size()), 32'(words.size()));
    for (int k = 0; k < words.size() && k < gotAddr.size(); k++) begin
      checkOutput($sformatf("%s_w%0d_addr", tag, k), 32'(gotAddr[k]), 32'(k));
      checkOutput($sformatf("%s_w%0d_data", tag, k), 32'(gotData[k]), words[k]);
    end
  endtask

  function automatic logic [7:0] byteSum(input logic [ILEN-1:0] w);
    logic [7:0] s;
    s = 8'h00;
    for (int b = 0; b < NB; b++) s = s + w[8*b +: 8];
    return s;
  endfunction

  // Send the whole frame for the current word list; corrupt adds one to
  // the checksum byte.
  task automatic sendFrame(input string tag, input bit corrupt);
    logic [15:0] n;
    logic [7:0]  sum;
    time         t0;
    n   = 16'(words.size());
    sum = n[7:0] + n[15:8];
    gotAddr.delete();
    gotData.delete();
    t0 = $time;
    applyStimulus(n[7:0]);
    checkOutput({tag, "_busy_len_hi"}, 32'(busy), 32'd1);
    applyStimulus(n[15:8]);
    for (int k = 0; k < words.size(); k++) begin
      for (int b = 0; b < NB; b++) applyStimulus(words[k][8*b +: 8]);
      sum = sum + byteSum(words[k]);
    end
    checkOutput({tag, "_run_before_csum"}, 32'(cpuRun), 32'd0);
    applyStimulus(corrupt ? sum + 8'd1 : sum);
    if (stallPct == 0)
      checkOutput({tag, "_cycles"}, 32'(($time - t0) / 10), 32'(NB * words.size() + 3));
    checkOutput({tag, "_run"},   32'(cpuRun), corrupt ? 32'd0 : 32'd1);
    checkOutput({tag, "_err"},   32'(err), corrupt ? 32'd1 : 32'd0);
    checkOutput({tag, "_ready"}, 32'(rxReady), 32'd0);
    checkOutput({tag, "_busy"},  32'(busy), 32'd0);
    checkWrites(tag);
  endtask

  task automatic doReload(input string tag);
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    checkOutput({tag, "_run"},   32'(cpuRun), 32'd0);
    checkOutput({tag, "_err"},   32'(err), 32'd0);
    checkOutput({tag, "_addr"},  32'(imemAddr), 32'd0);
    checkOutput({tag, "_ready"}, 32'(rxReady), 32'd1);
  endtask

  // Directed scenarios first, then randomized frames, then a full-depth load.
  initial begin
    logic [7:0] s;
    int         nw;

    rstN = 1'b0;
    idleCycles(3);
    checkResetValues("reset");
    rstN = 1'b1;
    idleCycles(1);

    // Normal two-word load, back to back; checksum works out to 0xE9.
    words = '{32'h0000_0013, 32'h0021_00B3};
    stallPct = 0;
    sendFrame("normal", 1'b0);
    doReload("reload_run");

    // Same frame with a wrong checksum byte; error must persist.
    sendFrame("badsum", 1'b1);
    idleCycles(4);
    checkOutput("badsum_persist_err", 32'(err), 32'd1);
    checkOutput("badsum_persist_run", 32'(cpuRun), 32'd0);
    doReload("reload_err");

    // N = 1025 exceeds the memory.
    gotAddr.delete();
    gotData.delete();
    applyStimulus(8'h01);
    applyStimulus(8'h04);
    checkOutput("oversize_err", 32'(err), 32'd2);
    checkOutput("oversize_ready", 32'(rxReady), 32'd0);
    idleCycles(5);
    checkOutput("oversize_writes", 32'(gotAddr.size()), 32'd0);
    doReload("reload_oversize");

    // Zero-length frame.
    words.delete();
    sendFrame("zero", 1'b0);
    doReload("reload_zero");

    // Timeout after the first data byte.
    gotAddr.delete();
    gotData.delete();
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'h13);
    idleCycles(TO - 1);
    checkOutput("timeout_err_early", 32'(err), 32'd0);
    checkOutput("timeout_busy_early", 32'(busy), 32'd1);
    idleCycles(1);
    checkOutput("timeout_err", 32'(err), 32'd3);
    checkOutput("timeout_ready", 32'(rxReady), 32'd0);
    checkOutput("timeout_writes", 32'(gotAddr.size()), 32'd0);
    doReload("reload_timeout");
    words = '{$urandom(), $urandom()};
    sendFrame("after_timeout", 1'b0);
    doReload("reload_after_timeout");

    // Bytes landing exactly on the terminal count beat the timeout.
    words = '{$urandom()};
    gotAddr.delete();
    gotData.delete();
    s = 8'h01 + byteSum(words[0]);
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    idleCycles(TO - 1);
    applyStimulus(words[0][7:0]);
    checkOutput("edge_err_data", 32'(err), 32'd0);
    checkOutput("edge_busy_data", 32'(busy), 32'd1);
    for (int b = 1; b < NB; b++) applyStimulus(words[0][8*b +: 8]);
    idleCycles(TO - 1);
    applyStimulus(s);
    checkOutput("edge_run", 32'(cpuRun), 32'd1);
    checkOutput("edge_err", 32'(err), 32'd0);
    checkWrites("edge");
    doReload("reload_edge");

    // Reset asserted while the second word's write is in flight.
    words = '{$urandom(), $urandom(), $urandom()};
    gotAddr.delete();
    gotData.delete();
    applyStimulus(8'h03);
    applyStimulus(8'h00);
    for (int k = 0; k < 2; k++)
      for (int b = 0; b < NB; b++) applyStimulus(words[k][8*b +: 8]);
    checkOutput("midrst_we_pending", 32'(imemWe), 32'd1);
    #1;
    rstN = 1'b0;
    #1;
    checkResetValues("midrst");
    checkOutput("midrst_writes", 32'(gotAddr.size()), 32'd1);
    if (gotData.size() > 0) checkOutput("midrst_word0", gotData[0], words[0]);
    @(posedge clk); #1;
    rstN = 1'b1;
    idleCycles(1);
    sendFrame("after_reset", 1'b0);
    doReload("reload_after_reset");

    // Randomized frames with stalls, ignored reload pulses and bad sums.
    stallPct = 40;
    reloadNoise = 1'b1;
    for (int f = 0; f < 20; f++) begin
      nw = int'($urandom_range(8, 1));
      words.delete();
      for (int k = 0; k < nw; k++) words.push_back($urandom());
      sendFrame($sformatf("rand%0d", f), ($urandom_range(3) == 0));
      doReload($sformatf("rand%0d_reload", f));
    end
    reloadNoise = 1'b0;

    // The two-word program again, with random valid gaps.
    words = '{32'h0000_0013, 32'h0021_00B3};
    sendFrame("stall_normal", 1'b0);
    doReload("reload_stall_normal");

    // Largest legal frame fills the whole memory.
    stallPct = 0;
    words.delete();
    for (int k = 0; k < DEPTH; k++) words.push_back($urandom());
    sendFrame("full", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
